qspis_wb_bridge: RTL and testbench

Downstream stage of the QSPI slave interface. It converts the level-held register requests (reg_wr/reg_rd with addr, be and wdata) into single classic Wishbone master cycles. It returns the read data and a one-cycle reg_ack, and bounds every bus cycle with a timeout. Bus errors and timeouts are converted into a defined error response plus sticky status.

---
 rtl/qspis_wb_bridge_pkg.sv | 28 ++
 rtl/qspis_wb_bridge.sv | 124 ++++++++++++
 tb/tb_qspis_wb_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qspis_wb_bridge_pkg.sv
// Shared types and constants for the QSPI slave register path.
// The bridge FSM state, the default error read-back word and the
// request-type encoding used between the QSPI interface and the bridge.
package qspis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } bridge_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WR   = 2'd1,
        REQ_RD   = 2'd2
    } req_type_t;

    // A write wins when upstream raises both request levels at once.
    function automatic req_type_t req_decode(input logic wr, input logic rd);
        if (wr) return REQ_WR;
        if (rd) return REQ_RD;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/qspis_wb_bridge.sv
// Register request to classic Wishbone master bridge.
// Each accepted level-held request becomes exactly one bus cycle, bounded
// by a saturating timeout. Errors and timeouts return ERR_DATA on reads and
// set a sticky flag plus the failing address.
module qspis_wb_bridge
    import qspis_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_W     = 8,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [31:0] reg_addr,
    input  logic [3:0]  reg_be,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        err_clr,
    output logic        err_sticky,
    output logic [31:0] err_addr
);

    // Counter value at which the current bus cycle has used its full budget.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    bridge_state_t   state;
    bridge_state_t   state_nxt;
    req_type_t       req_kind;
    logic [TO_W-1:0] to_cnt;
    logic            req_seen;
    logic            timed_out;
    logic            bus_err;
    logic            bus_done;
    logic            any_req;

    // Response decode and next-state selection.
    always_comb begin
        state_nxt = state;
        req_kind  = req_decode(reg_wr, reg_rd);
        timed_out = (to_cnt >= TO_LAST);
        bus_err   = wbm_err_i | (~wbm_ack_i & timed_out);
        bus_done  = wbm_ack_i | bus_err;
        // Upstream is still interested if it held a request in any BUS cycle.
        any_req   = req_seen | reg_wr | reg_rd;
        case (state)
            IDLE:    if (req_kind != REQ_NONE) state_nxt = BUS;
            BUS:     if (bus_done) state_nxt = any_req ? RESP : RELEASE;
            RESP:    state_nxt = RELEASE;
            RELEASE: if (!reg_wr && !reg_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bus signals, timeout counter, response data and error status.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_dat_o  <= '0;
            reg_ack    <= 1'b0;
            reg_rdata  <= '0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
            to_cnt     <= '0;
            req_seen   <= 1'b0;
        end else begin
            reg_ack <= 1'b0;
            if (err_clr) err_sticky <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_kind != REQ_NONE) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= (req_kind == REQ_WR);
                        wbm_adr_o <= reg_addr;
                        wbm_sel_o <= (req_kind == REQ_WR) ? reg_be : 4'hF;
                        wbm_dat_o <= reg_wdata;
                        to_cnt    <= '0;
                        req_seen  <= 1'b0;
                    end
                end
                BUS: begin
                    req_seen <= any_req;
                    if (bus_done) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        reg_ack   <= any_req;
                        if (!wbm_we_o) reg_rdata <= bus_err ? ERR_DATA : wbm_dat_i;
                        // Placed after the clear so a simultaneous error wins.
                        if (bus_err) begin
                            err_sticky <= 1'b1;
                            err_addr   <= wbm_adr_o;
                        end
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspis_wb_bridge.sv
// Self-checking bench for qspis_wb_bridge: directed scenarios plus random
// transactions against a transaction-level reference model.
module tb_qspis_wb_bridge;

    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        reg_wr, reg_rd;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  reg_be;
    logic        reg_ack;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i, wbm_err_i;
    logic        err_clr, err_sticky;
    logic [31:0] err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] m_rdata   = '0;
    logic        m_sticky  = 1'b0;
    logic [31:0] m_erraddr = '0;

    always #5 sys_clk = ~sys_clk;

    qspis_wb_bridge #(
        .TIMEOUT  (TO),
        .TO_W     (8),
        .ERR_DATA (ERRD)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_be     (reg_be),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_addr   (err_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 = slave acks after 'waits' wait states, 1 = slave errors, 2 = silent.
    // hold: cycles the request stays high after reg_ack is seen.
    // abort: request dropped right after acceptance.
    // clr_with: err_clr pulsed in the cycle the response is sampled.
    task automatic run_txn(input string name, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int waits, input int kind,
                           input logic [31:0] sdata, input int hold,
                           input bit abort, input bit clr_with);
        bit exp_we;
        bit is_err;
        int exp_cycles;
        int ack_t  = -1;
        int drop_t = -1;
        int n_ack  = 0;
        int n_cyc  = 0;
        int n_wb   = 0;
        bit prev_cyc = 1'b0;
        bit unstable = 1'b0;
        bit done     = 1'b0;

        exp_we     = wr;
        is_err     = (kind != 0) || (waits >= TO);
        exp_cycles = (kind == 2 || waits >= TO) ? TO : waits + 1;
        if (is_err) begin
            m_sticky  = 1'b1;
            m_erraddr = addr;
        end else if (clr_with) begin
            m_sticky = 1'b0;
        end
        if (!exp_we) m_rdata = is_err ? ERRD : sdata;

        @(negedge sys_clk);
        reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_be = be; reg_wdata = wdata;
        for (int t = 1; t <= 80; t++) begin
            @(negedge sys_clk);
            if (wbm_cyc_o) begin
                n_cyc++;
                if (!prev_cyc) begin
                    n_wb++;
                    if (n_wb == 1) begin
                        check_eq({name, ".adr"}, wbm_adr_o, addr);
                        check_eq({name, ".we"},  32'(wbm_we_o), 32'(exp_we));
                        check_eq({name, ".sel"}, 32'(wbm_sel_o), exp_we ? 32'(be) : 32'hF);
                        if (exp_we) check_eq({name, ".dat_o"}, wbm_dat_o, wdata);
                    end
                end
                if (wbm_adr_o !== addr || wbm_we_o !== exp_we || wbm_stb_o !== 1'b1) unstable = 1'b1;
            end
            prev_cyc = wbm_cyc_o;
            if (reg_ack) begin
                n_ack++;
                if (ack_t < 0) begin
                    ack_t = t;
                    check_eq({name, ".rdata"},  reg_rdata, m_rdata);
                    check_eq({name, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
                    check_eq({name, ".erraddr"}, err_addr, m_erraddr);
                end
            end
            // Slave and err_clr for the next edge.
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr = 1'b0; wbm_dat_i = $urandom;
            if (wbm_cyc_o && kind != 2 && n_cyc == waits + 1) begin
                if (kind == 0) begin
                    wbm_ack_i = 1'b1; wbm_dat_i = sdata;
                end else begin
                    wbm_err_i = 1'b1;
                end
            end
            if (wbm_cyc_o && n_cyc == exp_cycles) err_clr = clr_with;
            // Upstream request handling.
            if (drop_t < 0 && ((abort && t == 1) || (!abort && ack_t > 0 && t == ack_t + hold))) begin
                reg_wr = 1'b0; reg_rd = 1'b0; drop_t = t;
            end
            if (drop_t > 0 && t >= drop_t + 3 && !wbm_cyc_o) begin
                done = 1'b1;
                break;
            end
        end
        reg_wr = 1'b0; reg_rd = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr = 1'b0;
        check_eq({name, ".bounded"}, 32'(done), 32'd1);
        check_eq({name, ".n_ack"},   n_ack, abort ? 0 : 1);
        check_eq({name, ".n_wb"},    n_wb, 1);
        check_eq({name, ".cyc_len"}, n_cyc, exp_cycles);
        check_eq({name, ".stable"},  32'(unstable), 32'd0);
        if (!abort) check_eq({name, ".ack_lat"}, ack_t, exp_cycles + 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, ".cyc"},     32'(wbm_cyc_o), 0);
        check_eq({name, ".stb"},     32'(wbm_stb_o), 0);
        check_eq({name, ".we"},      32'(wbm_we_o), 0);
        check_eq({name, ".adr"},     wbm_adr_o, 0);
        check_eq({name, ".sel"},     32'(wbm_sel_o), 0);
        check_eq({name, ".dat_o"},   wbm_dat_o, 0);
        check_eq({name, ".ack"},     32'(reg_ack), 0);
        check_eq({name, ".rdata"},   reg_rdata, 0);
        check_eq({name, ".sticky"},  32'(err_sticky), 0);
        check_eq({name, ".erraddr"}, err_addr, 0);
    endtask

    initial begin
        bit wr, rd;
        int kind, waits;
        rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_be = '0;
        reg_wdata = '0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_txn("wr0", 1, 0, 32'h1000_0004, 4'h3, 32'hA5A5_1234, 0, 0, 32'h0, 0, 0, 0);
        run_txn("rd3", 0, 1, 32'h1000_0008, 4'h0, 32'h0, 3, 0, 32'hCAFE_0001, 0, 0, 0);
        run_txn("tmo", 0, 1, 32'h2000_0010, 4'h0, 32'h0, 0, 2, 32'h0, 0, 0, 0);

        @(negedge sys_clk); err_clr = 1'b1;
        @(negedge sys_clk); err_clr = 1'b0; m_sticky = 1'b0;
        check_eq("clr.sticky",  32'(err_sticky), 32'(m_sticky));
        check_eq("clr.erraddr", err_addr, m_erraddr);

        run_txn("wrerr", 1, 0, 32'h3000_0000, 4'hF, 32'h1111_2222, 1, 1, 32'h0, 0, 0, 0);
        run_txn("hold6", 0, 1, 32'h0000_0040, 4'h0, 32'h0, 0, 0, 32'h1234_5678, 6, 0, 0);
        run_txn("after", 0, 1, 32'h0000_0044, 4'h0, 32'h0, 2, 0, 32'h8765_4321, 0, 0, 0);
        run_txn("abort", 1, 0, 32'h0000_0050, 4'h5, 32'h5555_AAAA, 1, 0, 32'h0, 0, 1, 0);
        run_txn("both",  1, 1, 32'h0000_0060, 4'hC, 32'h0BAD_F00D, 0, 0, 32'h0, 0, 0, 0);
        run_txn("setwin", 0, 1, 32'h0000_0070, 4'h0, 32'h0, 2, 1, 32'h0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom % 2);
            rd    = wr ? 1'($urandom % 2) : 1'b1;
            kind  = $urandom_range(0, 9);
            kind  = (kind < 6) ? 0 : (kind < 9) ? 1 : 2;
            waits = ($urandom % 8 == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
            run_txn($sformatf("rnd%0d", i), wr, rd, $urandom, 4'($urandom), $urandom,
                    waits, kind, $urandom, $urandom_range(0, 3), 0, ($urandom % 4) == 0);
        end

        // Reset while a read sits in BUS against a silent slave.
        @(negedge sys_clk);
        reg_rd = 1'b1; reg_addr = 32'h4000_0000;
        repeat (3) @(negedge sys_clk);
        check_eq("prerst.cyc", 32'(wbm_cyc_o), 1);
        rst = 1'b1; reg_rd = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(negedge sys_clk);
            check_eq("postrst.ack", 32'(reg_ack), 0);
        end
        m_rdata = '0; m_sticky = 1'b0; m_erraddr = '0;
        run_txn("postrst", 0, 1, 32'h0000_0080, 4'h0, 32'h0, 1, 0, 32'h7777_0001, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
